// File: rtl/fp_minmax_pipe.sv
// fp_minmax_pipe: two-stage registered IEEE 754-2019 minimumNumber/maximumNumber.
// S1 captures the operands, the operation select and per-operand class bits.
// S2 resolves NaN handling and the ordered comparison, then registers the
// result and the invalid-operation flag. A single stall term freezes both
// stages while a presented result is not accepted.
module fp_minmax_pipe #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    localparam int FP_W = SIGN_W + EXPO_W + MANT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    input  logic            in_op_max,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_res,
    output logic            out_nv
);

    // Canonical quiet NaN: positive, all-ones exponent, only the quiet bit set.
    localparam logic [FP_W-1:0] CANON_QNAN =
        {{SIGN_W{1'b0}}, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    function automatic logic f_is_zero(input logic [FP_W-1:0] v);
        return (v[MANT_W +: EXPO_W] == {EXPO_W{1'b0}}) &&
               (v[MANT_W-1:0] == {MANT_W{1'b0}});
    endfunction

    function automatic logic f_is_nan(input logic [FP_W-1:0] v);
        return (v[MANT_W +: EXPO_W] == {EXPO_W{1'b1}}) &&
               (v[MANT_W-1:0] != {MANT_W{1'b0}});
    endfunction

    // Signalling NaN: a NaN whose quiet bit (fraction MSB) is clear.
    function automatic logic f_is_snan(input logic [FP_W-1:0] v);
        return f_is_nan(v) && (v[MANT_W-1] == 1'b0);
    endfunction

    // Strict ordering a < b for non-NaN operands; -0 orders below +0.
    function automatic logic f_less(input logic [FP_W-1:0] a,
                                    input logic [FP_W-1:0] b,
                                    input logic            a_zero,
                                    input logic            b_zero);
        logic                     lt;
        logic [EXPO_W+MANT_W-1:0] mag_a;
        logic [EXPO_W+MANT_W-1:0] mag_b;
        mag_a = a[EXPO_W+MANT_W-1:0];
        mag_b = b[EXPO_W+MANT_W-1:0];
        if (a_zero && b_zero) begin
            lt = a[FP_W-1] & ~b[FP_W-1];
        end else if (a[FP_W-1] != b[FP_W-1]) begin
            lt = a[FP_W-1];
        end else if (a[FP_W-1] == 1'b0) begin
            lt = (mag_a < mag_b);
        end else begin
            lt = (mag_a > mag_b);
        end
        return lt;
    endfunction

    logic            stall_s;
    logic            s1_valid_q,  s1_valid_d;
    logic [FP_W-1:0] s1_a_q,      s1_a_d;
    logic [FP_W-1:0] s1_b_q,      s1_b_d;
    logic            s1_op_max_q, s1_op_max_d;
    logic            s1_a_zero_q, s1_a_zero_d;
    logic            s1_a_nan_q,  s1_a_nan_d;
    logic            s1_a_snan_q, s1_a_snan_d;
    logic            s1_b_zero_q, s1_b_zero_d;
    logic            s1_b_nan_q,  s1_b_nan_d;
    logic            s1_b_snan_q, s1_b_snan_d;
    logic            out_valid_q, out_valid_d;
    logic [FP_W-1:0] out_res_q,   out_res_d;
    logic            out_nv_q,    out_nv_d;
    logic [FP_W-1:0] sel_res_s;
    logic            sel_nv_s;

    assign stall_s   = out_valid_q & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_nv    = out_nv_q;

    // Result selection from the S1 operands and their class bits.
    always_comb begin
        sel_res_s = s1_a_q;
        sel_nv_s  = s1_a_snan_q | s1_b_snan_q;
        if (s1_a_nan_q && s1_b_nan_q) begin
            sel_res_s = CANON_QNAN;
        end else if (s1_a_nan_q) begin
            sel_res_s = s1_b_q;
        end else if (s1_b_nan_q) begin
            sel_res_s = s1_a_q;
        end else if (s1_op_max_q) begin
            // max keeps A unless A is strictly smaller, so ties return A.
            sel_res_s = f_less(s1_a_q, s1_b_q, s1_a_zero_q, s1_b_zero_q) ? s1_b_q : s1_a_q;
        end else begin
            // min keeps A unless B is strictly smaller, so ties return A.
            sel_res_s = f_less(s1_b_q, s1_a_q, s1_b_zero_q, s1_a_zero_q) ? s1_b_q : s1_a_q;
        end
    end

    // Next-state for both stages; everything holds while the output is stalled.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_max_d = s1_op_max_q;
        s1_a_zero_d = s1_a_zero_q;
        s1_a_nan_d  = s1_a_nan_q;
        s1_a_snan_d = s1_a_snan_q;
        s1_b_zero_d = s1_b_zero_q;
        s1_b_nan_d  = s1_b_nan_q;
        s1_b_snan_d = s1_b_snan_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_nv_d    = out_nv_q;
        if (!stall_s) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                s1_a_d      = in_a;
                s1_b_d      = in_b;
                s1_op_max_d = in_op_max;
                s1_a_zero_d = f_is_zero(in_a);
                s1_a_nan_d  = f_is_nan(in_a);
                s1_a_snan_d = f_is_snan(in_a);
                s1_b_zero_d = f_is_zero(in_b);
                s1_b_nan_d  = f_is_nan(in_b);
                s1_b_snan_d = f_is_snan(in_b);
            end else begin
                s1_a_d = s1_a_q;
            end
            if (s1_valid_q) begin
                out_res_d = sel_res_s;
                out_nv_d  = sel_nv_s;
            end else begin
                out_res_d = out_res_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {FP_W{1'b0}};
            s1_b_q      <= {FP_W{1'b0}};
            s1_op_max_q <= 1'b0;
            s1_a_zero_q <= 1'b0;
            s1_a_nan_q  <= 1'b0;
            s1_a_snan_q <= 1'b0;
            s1_b_zero_q <= 1'b0;
            s1_b_nan_q  <= 1'b0;
            s1_b_snan_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= {FP_W{1'b0}};
            out_nv_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_max_q <= s1_op_max_d;
            s1_a_zero_q <= s1_a_zero_d;
            s1_a_nan_q  <= s1_a_nan_d;
            s1_a_snan_q <= s1_a_snan_d;
            s1_b_zero_q <= s1_b_zero_d;
            s1_b_nan_q  <= s1_b_nan_d;
            s1_b_snan_q <= s1_b_snan_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_nv_q    <= out_nv_d;
        end
    end

endmodule

// File: tb/tb_fp_minmax_pipe.sv
// Scoreboard bench for fp_minmax_pipe (binary32). The driver pushes the
// hand-computed result when a pair is accepted; the monitor compares the
// queue head whenever a result is presented and pops it when it is consumed.
module tb_fp_minmax_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
        logic        nv;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op_max;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_nv;

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    logic [32:0] sb[$];

    fp_minmax_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op_max (in_op_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_nv    (out_nv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one pair, hold it until accepted, record the expected result.
    task automatic send(input vec_t v);
        int  n;
        bit  done;
        @(negedge clk);
        in_a      = v.a;
        in_b      = v.b;
        in_op_max = v.op;
        in_valid  = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            #1;
            if (in_ready) begin
                sb.push_back({v.r, v.nv});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    chk("send_timeout", 64'd1, 64'd0);
                    in_valid = 1'b0;
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compare every presented result with the scoreboard head.
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {31'd0, out_res, out_nv}, 64'd0);
                end else begin
                    exp = sb[0];
                    chk("result", {31'd0, out_res, out_nv}, {31'd0, exp});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t vecs [12];
        vec_t stv  [4];
        vec_t first;
        int   p0;
        int   n;

        first   = '{32'h3F800000, 32'h40000000, 1'b0, 32'h3F800000, 1'b0};
        vecs[0]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 1'b0};
        vecs[1]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
        vecs[2]  = '{32'h7FC00000, 32'hC0000000, 1'b0, 32'hC0000000, 1'b0};
        vecs[3]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b1};
        vecs[4]  = '{32'h7F800001, 32'h7FC00001, 1'b1, 32'h7FC00000, 1'b1};
        vecs[5]  = '{32'h7F800001, 32'hFF800002, 1'b0, 32'h7FC00000, 1'b1};
        vecs[6]  = '{32'h40000000, 32'hFFC00000, 1'b1, 32'h40000000, 1'b0};
        vecs[7]  = '{32'h7F800000, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 1'b0};
        vecs[8]  = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000001, 1'b0};
        vecs[9]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0};
        vecs[10] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'hBF800000, 1'b0};
        vecs[11] = '{32'hC0000000, 32'hBF800000, 1'b1, 32'hBF800000, 1'b0};

        stv[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h3F800000, 1'b0};
        stv[1] = '{32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 1'b0};
        stv[2] = '{32'hC0000000, 32'hBF800000, 1'b0, 32'hC0000000, 1'b0};
        stv[3] = '{32'hC0000000, 32'hBF800000, 1'b1, 32'hBF800000, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_op_max = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_res",   64'(out_res),   64'd0);
        chk("reset_out_nv",    64'(out_nv),    64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;

        // First pair: exact two-cycle latency.
        send(first);
        @(negedge clk);
        #1;
        chk("latency_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("latency_due", 64'(out_valid), 64'd1);
        drain();

        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Back-to-back pairs with a three-cycle consumer stall.
        p0 = pops;
        fork
            begin
                for (int k = 0; k < 4; k++) send(stv[k]);
            end
            begin
                int m;
                m = 0;
                do begin
                    @(negedge clk);
                    #1;
                    m++;
                end while (!out_valid && m < 20);
                chk("stall_first_seen", 64'(out_valid), 64'd1);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    out_ready = 1'b0;
                    #1;
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(pops - p0), 64'd4);

        // Reset with two pairs in flight.
        @(negedge clk);
        out_ready = 1'b0;
        send(vecs[10]);
        send(vecs[11]);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_flush_valid", 64'(out_valid), 64'd0);
        chk("rst_flush_ready", 64'(in_ready),  64'd1);
        sb.delete();
        rst       = 1'b0;
        out_ready = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid) n++;
        end
        chk("rst_no_stale", 64'(n), 64'd0);
        send(vecs[3]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
